// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// decode_queue : RV32I decode stage fronted by a DEPTH-entry FIFO; decoding
//                happens at push time so all head outputs are register-driven.
// Revision     : 1.0
// ============================================================================
module decode_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [4:0]               rs1_addr,
    output logic [4:0]               rs2_addr,
    output logic [4:0]               rd_addr,
    output logic [31:0]              imm,
    output logic [3:0]               alu_op,
    output logic [2:0]               br_op,
    output logic [3:0]               ld_op,
    output logic                     rd_wren,
    output logic                     mem_wren,
    output logic                     is_load,
    output logic                     op_a_sel,
    output logic                     op_b_sel,
    output logic                     branch,
    output logic                     jump,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic [2:0]  br_op;
        logic [3:0]  ld_op;
        logic        rd_wren;
        logic        mem_wren;
        logic        is_load;
        logic        op_a_sel;
        logic        op_b_sel;
        logic        branch;
        logic        jump;
        logic        illegal;
    } entry_t;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt,
                                           input logic allow_sub);
        logic [3:0] r;
        r = 4'd0;
        case (f3)
            3'b000: r = (allow_sub && alt) ? 4'd1 : 4'd0;
            3'b001: r = 4'd7;
            3'b010: r = 4'd2;
            3'b011: r = 4'd3;
            3'b100: r = 4'd4;
            3'b101: r = alt ? 4'd9 : 4'd8;
            3'b110: r = 4'd5;
            default: r = 4'd6;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] mem_sel(input logic [2:0] f3);
        logic [3:0] r;
        case (f3)
            3'b000:  r = 4'b1001;
            3'b001:  r = 4'b1011;
            3'b010:  r = 4'b1111;
            3'b100:  r = 4'b0001;
            3'b101:  r = 4'b0011;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    logic [6:0] opc_w;
    logic [2:0] f3_w;
    logic [6:0] f7_w;
    logic [4:0] rd_f_w;
    logic [4:0] rs1_f_w;
    logic [4:0] rs2_f_w;
    logic [31:0] imm_i_w, imm_s_w, imm_b_w, imm_u_w, imm_j_w;

    assign opc_w   = in_instr[6:0];
    assign f3_w    = in_instr[14:12];
    assign f7_w    = in_instr[31:25];
    assign rd_f_w  = in_instr[11:7];
    assign rs1_f_w = in_instr[19:15];
    assign rs2_f_w = in_instr[24:20];
    assign imm_i_w = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s_w = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b_w = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
    assign imm_u_w = {in_instr[31:12], 12'd0};
    assign imm_j_w = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};

    entry_t dec_d;
    logic   has_rd_d;
    logic   bad_d;

    always_comb begin
        dec_d       = '0;
        has_rd_d    = 1'b0;
        bad_d       = 1'b0;
        dec_d.pc    = in_pc;
        dec_d.instr = in_instr;
        dec_d.op_b_sel = (opc_w != OPC_OP);
        case (opc_w)
            OPC_LUI: begin
                dec_d.imm = imm_u_w;
                has_rd_d  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.imm      = imm_u_w;
                dec_d.op_a_sel = 1'b1;
                has_rd_d       = 1'b1;
            end
            OPC_JAL: begin
                dec_d.imm      = imm_j_w;
                dec_d.br_op    = 3'd6;
                dec_d.op_a_sel = 1'b1;
                dec_d.branch   = 1'b1;
                dec_d.jump     = 1'b1;
                has_rd_d       = 1'b1;
            end
            OPC_JALR: begin
                dec_d.imm    = imm_i_w;
                dec_d.rs1    = rs1_f_w;
                dec_d.br_op  = 3'd7;
                dec_d.branch = 1'b1;
                dec_d.jump   = 1'b1;
                has_rd_d     = 1'b1;
            end
            OPC_BRANCH: begin
                dec_d.imm      = imm_b_w;
                dec_d.rs1      = rs1_f_w;
                dec_d.rs2      = rs2_f_w;
                dec_d.op_a_sel = 1'b1;
                dec_d.branch   = 1'b1;
                case (f3_w)
                    3'b000:  dec_d.br_op = 3'd0;
                    3'b001:  dec_d.br_op = 3'd1;
                    3'b100:  dec_d.br_op = 3'd2;
                    3'b101:  dec_d.br_op = 3'd3;
                    3'b110:  dec_d.br_op = 3'd4;
                    3'b111:  dec_d.br_op = 3'd5;
                    default: bad_d       = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_d.imm     = imm_i_w;
                dec_d.rs1     = rs1_f_w;
                dec_d.ld_op   = mem_sel(f3_w);
                dec_d.is_load = 1'b1;
                has_rd_d      = 1'b1;
                bad_d         = (f3_w == 3'b011) || (f3_w[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_d.imm      = imm_s_w;
                dec_d.rs1      = rs1_f_w;
                dec_d.rs2      = rs2_f_w;
                dec_d.ld_op    = mem_sel(f3_w);
                dec_d.mem_wren = 1'b1;
                bad_d          = (f3_w > 3'b010);
            end
            OPC_OPIMM: begin
                dec_d.imm    = imm_i_w;
                dec_d.rs1    = rs1_f_w;
                dec_d.alu_op = alu_sel(f3_w, in_instr[30], 1'b0);
                has_rd_d     = 1'b1;
                // srai is the only immediate shift allowed a non-zero funct7
                if (f3_w == 3'b001)
                    bad_d = (f7_w != 7'b0000000);
                else if (f3_w == 3'b101)
                    bad_d = (f7_w != 7'b0000000) && (f7_w != 7'b0100000);
            end
            OPC_OP: begin
                dec_d.rs1    = rs1_f_w;
                dec_d.rs2    = rs2_f_w;
                dec_d.alu_op = alu_sel(f3_w, in_instr[30], 1'b1);
                has_rd_d     = 1'b1;
                bad_d        = !((f7_w == 7'b0000000) ||
                                 ((f7_w == 7'b0100000) &&
                                  ((f3_w == 3'b000) || (f3_w == 3'b101))));
            end
            default: bad_d = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11)
            bad_d = 1'b1;
        if (has_rd_d)
            dec_d.rd = rd_f_w;
        dec_d.rd_wren = has_rd_d && (rd_f_w != 5'd0);
        dec_d.illegal = bad_d;
        if (bad_d) begin
            dec_d.rd_wren  = 1'b0;
            dec_d.mem_wren = 1'b0;
            dec_d.is_load  = 1'b0;
            dec_d.branch   = 1'b0;
            dec_d.jump     = 1'b0;
        end
    end

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_w, pop_w;
    entry_t        head_w;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push_w    = in_valid && in_ready;
    assign pop_w     = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w)
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_w)
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_w && !pop_w)
                count_d = count_q + CNT_ONE;
            else if (pop_w && !push_w)
                count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_w && !flush)
            mem_q[wr_ptr_q] <= dec_d;
    end

    // Storage is never reset, so the head is masked while the queue is empty
    assign head_w = out_valid ? mem_q[rd_ptr_q] : '0;

    assign out_pc    = head_w.pc;
    assign out_instr = head_w.instr;
    assign rs1_addr  = head_w.rs1;
    assign rs2_addr  = head_w.rs2;
    assign rd_addr   = head_w.rd;
    assign imm       = head_w.imm;
    assign alu_op    = head_w.alu_op;
    assign br_op     = head_w.br_op;
    assign ld_op     = head_w.ld_op;
    assign rd_wren   = head_w.rd_wren;
    assign mem_wren  = head_w.mem_wren;
    assign is_load   = head_w.is_load;
    assign op_a_sel  = head_w.op_a_sel;
    assign op_b_sel  = head_w.op_b_sel;
    assign branch    = head_w.branch;
    assign jump      = head_w.jump;
    assign illegal   = head_w.illegal;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// tb_decode_queue : directed self-checking bench for decode_queue (DEPTH=4).
// Revision        : 1.0
// ============================================================================
module tb_decode_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc, out_instr, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_op, ld_op;
    logic [2:0]  br_op;
    logic        rd_wren, mem_wren, is_load, op_a_sel, op_b_sel, branch, jump, illegal;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    decode_queue #(.DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_pc(out_pc), .out_instr(out_instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .imm(imm),
        .alu_op(alu_op), .br_op(br_op), .ld_op(ld_op),
        .rd_wren(rd_wren), .mem_wren(mem_wren), .is_load(is_load),
        .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .branch(branch), .jump(jump),
        .illegal(illegal), .count(count)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #3 rst_ni = 1'b0;
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_rd_wren", rd_wren, 0);
        check_eq("rst_imm", imm, 0);
        tick();
        tick();
        rst_ni = 1'b1;

        // addi x5,x0,-1 into empty queue, pushed on first edge after reset
        push_one(32'hFFF00293, 32'h100);
        check_eq("addi_valid", out_valid, 1);
        check_eq("addi_pc", out_pc, 32'h100);
        check_eq("addi_rd", rd_addr, 5);
        check_eq("addi_imm", imm, 32'hFFFFFFFF);
        check_eq("addi_alu", alu_op, 0);
        check_eq("addi_opb", op_b_sel, 1);
        check_eq("addi_rdwren", rd_wren, 1);
        check_eq("addi_illegal", illegal, 0);
        check_eq("addi_count", count, 1);
        pop_one();
        check_eq("pop_count", count, 0);
        check_eq("pop_valid", out_valid, 0);

        // five back-to-back pushes into a DEPTH=4 queue
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_instr = 32'h00000013;
            in_pc    = 32'h200 + 32'(i * 4);
            tick();
        end
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_count", count, 4);
        check_eq("full_head_pc", out_pc, 32'h200);
        // full queue, push and pop together: only the pop happens
        in_pc     = 32'h300;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("fullpp_count", count, 3);
        for (int i = 1; i < 4; i++) begin
            check_eq("order_pc", out_pc, 32'h200 + 32'(i * 4));
            pop_one();
        end
        check_eq("drain_count", count, 0);
        check_eq("drain_valid", out_valid, 0);

        // directed decode vectors
        push_one(32'h00000000, 32'h400);
        check_eq("zero_illegal", illegal, 1);
        check_eq("zero_rdwren", rd_wren, 0);
        pop_one();

        push_one(32'h40208033, 32'h404);  // sub x0,x1,x2
        check_eq("sub_alu", alu_op, 1);
        check_eq("sub_rdwren", rd_wren, 0);
        check_eq("sub_opb", op_b_sel, 0);
        check_eq("sub_rs1", rs1_addr, 1);
        check_eq("sub_rs2", rs2_addr, 2);
        check_eq("sub_illegal", illegal, 0);
        pop_one();

        push_one(32'h000100E7, 32'h408);  // jalr x1,0(x2)
        check_eq("jalr_brop", br_op, 7);
        check_eq("jalr_jump", jump, 1);
        check_eq("jalr_branch", branch, 1);
        check_eq("jalr_opa", op_a_sel, 0);
        check_eq("jalr_rdwren", rd_wren, 1);
        pop_one();

        push_one(32'h00002063, 32'h40C);  // beq encoding with funct3=010
        check_eq("badbr_illegal", illegal, 1);
        check_eq("badbr_branch", branch, 0);
        pop_one();

        push_one(32'hFFC39303, 32'h410);  // lh x6,-4(x7)
        check_eq("lh_ldop", ld_op, 4'b1011);
        check_eq("lh_isload", is_load, 1);
        check_eq("lh_imm", imm, 32'hFFFFFFFC);
        check_eq("lh_rd", rd_addr, 6);
        pop_one();

        push_one(32'h00532623, 32'h414);  // sw x5,12(x6)
        check_eq("sw_memwren", mem_wren, 1);
        check_eq("sw_ldop", ld_op, 4'b1111);
        check_eq("sw_imm", imm, 32'd12);
        check_eq("sw_rdwren", rd_wren, 0);
        pop_one();

        push_one(32'h40315093, 32'h418);  // srai x1,x2,3
        check_eq("srai_alu", alu_op, 9);
        check_eq("srai_illegal", illegal, 0);
        pop_one();

        push_one(32'hFE209CE3, 32'h41C);  // bne x1,x2,-8
        check_eq("bne_brop", br_op, 1);
        check_eq("bne_imm", imm, 32'hFFFFFFF8);
        check_eq("bne_opa", op_a_sel, 1);
        check_eq("bne_branch", branch, 1);
        check_eq("bne_jump", jump, 0);
        pop_one();

        push_one(32'h12345537, 32'h420);  // lui x10,0x12345
        check_eq("lui_imm", imm, 32'h12345000);
        check_eq("lui_rd", rd_addr, 10);
        check_eq("lui_rdwren", rd_wren, 1);
        check_eq("lui_opa", op_a_sel, 0);
        check_eq("lui_instr", out_instr, 32'h12345537);
        pop_one();

        // flush at count=3 with a same-cycle push
        for (int i = 0; i < 3; i++)
            push_one(32'h00000013, 32'h500 + 32'(i * 4));
        check_eq("preflush_count", count, 3);
        in_valid = 1'b1;
        in_pc    = 32'h50C;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_count", count, 0);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_in_ready", in_ready, 1);
        push_one(32'h00000013, 32'h600);
        check_eq("postflush_count", count, 1);
        check_eq("postflush_pc", out_pc, 32'h600);
        pop_one();

        // asynchronous reset with two entries queued
        push_one(32'h00000013, 32'h680);
        push_one(32'h00000013, 32'h684);
        check_eq("prereset_count", count, 2);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_count", count, 0);
        check_eq("arst_pc", out_pc, 0);
        check_eq("arst_in_ready", in_ready, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        push_one(32'h00000013, 32'h700);
        check_eq("post_arst_count", count, 1);
        check_eq("post_arst_pc", out_pc, 32'h700);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
